// File: rtl/latch_mon_pkg.sv
// latch_mon_pkg: shared types and constants for latch_out_monitor.
//   - mon_state_e : debounce FSM states
//   - DEF_*       : default parameter values
//   - deb_cnt_w() : width of the debounce / mismatch counters
package latch_mon_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } mon_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE    = 4;
    localparam int DEF_CNT_W       = 8;

    // One extra bit so the counter can also hold the value DEBOUNCE itself.
    function automatic int deb_cnt_w(input int debounce);
        return $clog2(debounce) + 1;
    endfunction

endpackage

// File: rtl/latch_out_monitor_if.sv
// latch_out_monitor_if: latch output pair in, debounced observation out.
//   in_q, in_q_bar : latch outputs (asynchronous to clk)
//   in_clr         : synchronous clear of out_count / out_err
//   out_level      : committed level of Q
//   out_rise/fall  : one-cycle pulses on committed edges
//   out_count      : saturating count of committed rises
//   out_err        : sticky invalid-pair flag (LATCH_PAIR_CHECK_EN builds only)
// master = stimulus side, slave = monitor side.
interface latch_out_monitor_if
    import latch_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             in_q;
    logic             in_q_bar;
    logic             in_clr;
    logic             out_level;
    logic             out_rise;
    logic             out_fall;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    modport master (
        output in_q, in_q_bar, in_clr,
        input  out_level, out_rise, out_fall, out_count, out_err
    );

    modport slave (
        input  in_q, in_q_bar, in_clr,
        output out_level, out_rise, out_fall, out_count, out_err
    );
endinterface

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: STAGES-deep flop chain bringing a 1-bit asynchronous
// input into the clk domain.
//   clk, reset : clock, synchronous active-high reset (chain -> 0)
//   d          : asynchronous input
//   q          : synchronised output (last stage)
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_r;

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];
endmodule

// File: rtl/latch_out_monitor.sv
// latch_out_monitor: synchronises a latch (Q, Q_bar) pair, debounces Q and
// reports a clean level, rise/fall pulses and a saturating rise counter.
//   clk, reset : clock, synchronous active-high reset
//   bus        : latch_out_monitor_if.slave (inputs and all outputs)
// Optional feature macro: LATCH_PAIR_CHECK_EN - when defined, out_err flags
// DEBOUNCE consecutive synchronised samples with Q == Q_bar; otherwise
// out_err is 0 and in_q_bar is ignored.
module latch_out_monitor
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic              clk,
    input logic              reset,
    latch_out_monitor_if.slave bus
);
    localparam int               DC_W     = deb_cnt_w(DEBOUNCE);
    localparam logic [DC_W-1:0]  DC_ZERO  = {DC_W{1'b0}};
    localparam logic [DC_W-1:0]  DC_ONE   = {{(DC_W-1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0]  DEB_LAST = DC_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             sync_q_s;
    mon_state_e       state_r, state_nxt_s;
    logic [DC_W-1:0]  deb_cnt_r, deb_cnt_nxt_s;
    logic             level_r, level_nxt_s;
    logic             rise_r, rise_nxt_s;
    logic             fall_r, fall_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             err_r;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_q (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in_q),
        .q     (sync_q_s)
    );

    // Debounce FSM: a level change commits after DEBOUNCE consecutive samples.
    always_comb begin
        state_nxt_s   = state_r;
        deb_cnt_nxt_s = deb_cnt_r;
        level_nxt_s   = level_r;
        rise_nxt_s    = 1'b0;
        fall_nxt_s    = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (sync_q_s) begin
                    state_nxt_s   = ST_RISE_CHK;
                    deb_cnt_nxt_s = DC_ONE;
                end else begin
                    deb_cnt_nxt_s = DC_ZERO;
                end
            end
            ST_RISE_CHK: begin
                if (!sync_q_s) begin
                    state_nxt_s   = ST_LOW;
                    deb_cnt_nxt_s = DC_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s   = ST_HIGH;
                    deb_cnt_nxt_s = DC_ZERO;
                    level_nxt_s   = 1'b1;
                    rise_nxt_s    = 1'b1;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DC_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_q_s) begin
                    state_nxt_s   = ST_FALL_CHK;
                    deb_cnt_nxt_s = DC_ONE;
                end else begin
                    deb_cnt_nxt_s = DC_ZERO;
                end
            end
            ST_FALL_CHK: begin
                if (sync_q_s) begin
                    state_nxt_s   = ST_HIGH;
                    deb_cnt_nxt_s = DC_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s   = ST_LOW;
                    deb_cnt_nxt_s = DC_ZERO;
                    level_nxt_s   = 1'b0;
                    fall_nxt_s    = 1'b1;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DC_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_LOW;
                deb_cnt_nxt_s = DC_ZERO;
                level_nxt_s   = 1'b0;
            end
        endcase
    end

    // Rise counter: clear wins over the old value but still counts a same-cycle rise.
    always_comb begin
        count_nxt_s = count_r;
        if (bus.in_clr) begin
            count_nxt_s = rise_nxt_s ? CNT_ONE : CNT_ZERO;
        end else if (rise_nxt_s && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_LOW;
            deb_cnt_r <= DC_ZERO;
            level_r   <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            count_r   <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            level_r   <= level_nxt_s;
            rise_r    <= rise_nxt_s;
            fall_r    <= fall_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

`ifdef LATCH_PAIR_CHECK_EN
    localparam logic [DC_W-1:0] DEB_FULL = DC_W'(DEBOUNCE);

    logic            sync_qb_s;
    logic [DC_W-1:0] mis_cnt_r, mis_cnt_nxt_s;
    logic            err_hit_s, err_nxt_s;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_qb (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in_q_bar),
        .q     (sync_qb_s)
    );

    // Count consecutive non-complementary samples; flag once the run hits DEBOUNCE.
    always_comb begin
        mis_cnt_nxt_s = mis_cnt_r;
        err_hit_s     = 1'b0;
        if (sync_q_s != sync_qb_s) begin
            mis_cnt_nxt_s = DC_ZERO;
        end else if (mis_cnt_r == DEB_FULL) begin
            mis_cnt_nxt_s = mis_cnt_r;
        end else begin
            mis_cnt_nxt_s = mis_cnt_r + DC_ONE;
            err_hit_s     = (mis_cnt_r == DEB_LAST);
        end
        if (err_hit_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.in_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Mismatch counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_cnt_r <= DC_ZERO;
            err_r     <= 1'b0;
        end else begin
            mis_cnt_r <= mis_cnt_nxt_s;
            err_r     <= err_nxt_s;
        end
    end
`else
    logic unused_qb_s;
    assign unused_qb_s = bus.in_q_bar;
    assign err_r       = 1'b0;
`endif

    assign bus.out_level = level_r;
    assign bus.out_rise  = rise_r;
    assign bus.out_fall  = fall_r;
    assign bus.out_count = count_r;
    assign bus.out_err   = err_r;
endmodule

// File: tb/tb_latch_out_monitor.sv
// tb_latch_out_monitor: randomized + directed stimulus for latch_out_monitor.
// A reference model (sample delay line + run lengths) pushes the expected
// outputs for every clock into a queue; an independent monitor pops and
// compares on each falling edge.
module tb_latch_out_monitor;
    import latch_mon_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          level;
        logic          rise;
        logic          fall;
        logic [CW-1:0] count;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state.
    bit m_q_pipe[$];
    bit m_qb_pipe[$];
    bit m_level;
    int m_run;
    int m_cnt;
    int m_eq_run;
    bit m_err;

    latch_out_monitor_if #(.CNT_W(CW)) bus ();

    latch_out_monitor #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE    (DEB),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Model one rising edge from the inputs currently applied.
    task automatic model_step();
        exp_t e;
        bit   s, sb, rise, fall;
        rise = 1'b0;
        fall = 1'b0;
        if (reset) begin
            m_q_pipe  = {};
            m_qb_pipe = {};
            for (int i = 0; i < SYNC; i++) begin
                m_q_pipe.push_back(1'b0);
                m_qb_pipe.push_back(1'b0);
            end
            m_level = 1'b0; m_run = 0; m_cnt = 0; m_eq_run = 0; m_err = 1'b0;
        end else begin
            // Value the debouncer sees now: what entered the chain SYNC edges ago.
            s  = m_q_pipe[SYNC-1];
            sb = m_qb_pipe[SYNC-1];
            void'(m_q_pipe.pop_back());
            void'(m_qb_pipe.pop_back());
            m_q_pipe.push_front(bus.in_q);
            m_qb_pipe.push_front(bus.in_q_bar);
            // Commit when DEBOUNCE consecutive samples disagree with the level.
            if (s != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = s;
                    m_run   = 0;
                    rise    = s;
                    fall    = !s;
                end
            end else begin
                m_run = 0;
            end
            if (bus.in_clr)                  m_cnt = rise ? 1 : 0;
            else if (rise && m_cnt < CMAX)   m_cnt++;
`ifdef LATCH_PAIR_CHECK_EN
            m_eq_run = (s == sb) ? m_eq_run + 1 : 0;
            if (m_eq_run == DEB)             m_err = 1'b1;
            else if (bus.in_clr)             m_err = 1'b0;
`endif
        end
        e.level = m_level;
        e.rise  = rise;
        e.fall  = fall;
        e.count = m_cnt[CW-1:0];
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit q, input bit qb, input bit clr, input bit rst);
        @(negedge clk);
        bus.in_q     = q;
        bus.in_q_bar = qb;
        bus.in_clr   = clr;
        reset        = rst;
        @(posedge clk);
        model_step();
    endtask

    task automatic hold(input bit q, input int n);
        for (int i = 0; i < n; i++) drive(q, !q, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the next expected entry.
    initial begin : monitor
        exp_t e;
        bit   prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level", int'(bus.out_level), int'(e.level));
                chk("rise",  int'(bus.out_rise),  int'(e.rise));
                chk("fall",  int'(bus.out_fall),  int'(e.fall));
                chk("count", int'(bus.out_count), int'(e.count));
                chk("err",   int'(bus.out_err),   int'(e.err));
                chk("pulse_spacing",
                    int'((bus.out_rise && bus.out_fall) ||
                         (prev_pulse && (bus.out_rise || bus.out_fall))), 0);
                prev_pulse = bus.out_rise || bus.out_fall;
            end
        end
    end

    initial begin : stimulus
        bit q, qb, clr;
        int len;
        reset        = 1'b1;
        bus.in_q     = 1'b0;
        bus.in_q_bar = 1'b1;
        bus.in_clr   = 1'b0;

        // Reset held with in_q=1, then release: rise 6 edges later.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);

        // Two-cycle glitch is rejected.
        hold(1'b1, 2);
        hold(1'b0, 8);

        // Reset two cycles into the rise check discards the pending change.
        hold(1'b1, 4);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);

        // Randomized segments, occasional invalid pair and clears.
        for (int seg = 0; seg < 300; seg++) begin
            q   = $urandom_range(0, 1);
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                qb  = ($urandom_range(0, 15) == 0) ? q : !q;
                clr = ($urandom_range(0, 19) == 0);
                drive(q, qb, clr, 1'b0);
            end
        end

        // Saturation: clear, then 260 clean rise/fall cycles.
        hold(1'b0, 10);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 260; n++) begin
            hold(1'b1, 6);
            hold(1'b0, 6);
        end
        // Next rise commits on the 6th edge; clear lands on that same edge.
        hold(1'b1, 5);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        hold(1'b0, 10);

        // Invalid pair held for 8 cycles, then restore and clear.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b0, 4);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b0, 6);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latch_out_monitor.md
Name: latch_out_monitor

Overview:
- Downstream consumer of the D-latch-with-SR output pair (q, q_bar) in the latch/flip-flop library.
- Synchronises the latch outputs into the system clock domain and debounces the level.
- Emits one-cycle rise/fall pulses, a clean level and a saturating rise-event counter, so latch behaviour can be observed by clocked logic and the bench.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops per input; legal values 2..4.
- DEBOUNCE, 4, consecutive stable samples needed to commit a level change; legal values 2..16.
- CNT_W, 8, width of the rise-event counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_q  input  1  latch Q output (asynchronous to clk).
- in_q_bar  input  1  latch Q_bar output (asynchronous to clk).
- in_clr  input  1  synchronous clear of out_count and out_err.
- out_level  output  1  debounced, committed level of Q.
- out_rise  output  1  one-cycle pulse on a committed 0->1 change.
- out_fall  output  1  one-cycle pulse on a committed 1->0 change.
- out_count  output  CNT_W  number of committed rises; saturates.
- out_err  output  1  sticky pair-check error; active only with the optional feature.

Behaviour:
- Reset:
  - Synchroniser flops = 0; state = ST_LOW; stable counter = 0.
  - out_level = 0, out_rise = 0, out_fall = 0, out_count = 0, out_err = 0.
  - Reset asserted mid-debounce discards the pending change.
  - Reset overrides in_clr and all other events.
- Synchroniser: in_q and in_q_bar each pass through SYNC_STAGES flops. The last stage gives sync_q and sync_qb.
- FSM states: ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK.
  - ST_LOW: if sync_q=1, go to ST_RISE_CHK with cnt=1; else stay.
  - ST_RISE_CHK:
    - If sync_q=0 (glitch), go to ST_LOW with cnt=0 and no pulse.
    - Else if cnt==DEBOUNCE-1, go to ST_HIGH: out_level<=1, out_rise<=1 for one cycle, count updates.
    - Else cnt<=cnt+1.
  - ST_HIGH and ST_FALL_CHK mirror the rise path, using sync_q=0, out_fall and out_level<=0.
- Outputs are registered. out_rise and out_fall are never high in the same cycle and never high on consecutive cycles.
- Latency: in_q stable from edge 1 (first edge sampling the new value) gives out_rise high in the cycle after edge SYNC_STAGES+DEBOUNCE. With defaults that is edge 6.
- A pulse shorter than SYNC_STAGES+DEBOUNCE-1 cycles may be lost. A pulse of DEBOUNCE-1 or fewer synchronised samples is always rejected.
- Counter:
  - Increments by 1 on each committed rise.
  - Holds at 2^CNT_W-1 (saturates, no wrap).
  - in_clr sets it to 0. If in_clr and a committed rise occur in the same cycle, out_count=1.
- in_clr has no effect on the FSM, out_level or the synchronisers.

Optional Feature:
- Macro: LATCH_PAIR_CHECK_EN.
- Defined:
  - A second counter tracks consecutive cycles with sync_q==sync_qb (invalid complementary pair).
  - When it reaches DEBOUNCE, out_err<=1 and stays sticky until reset or in_clr. If in_clr and a new detection occur in the same cycle, out_err=1.
  - The mismatch counter resets whenever sync_q!=sync_qb.
- Not defined: out_err tied to 0, in_q_bar unused, and no check logic is synthesised. The port list is identical in both builds.

Decomposition:
- Package latch_mon_pkg holds:
  - the state enum (ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK);
  - the default parameter constants;
  - a localparam function for the debounce counter width, $clog2(DEBOUNCE)+1.
- One sub-module: sync_ff_chain (parameter STAGES, 1-bit in/out, synchronous reset to 0), instantiated once per input.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE=4, CNT_W=8):
- Reset held for 3 cycles with in_q=1 -> all outputs 0 during reset. After release, out_rise pulses once at edge 6 after release; out_level=1; out_count=1.
- in_q 0->1 held for 10 cycles, then 1->0 -> out_rise for one cycle at edge 6; out_fall for one cycle 6 edges after the fall; out_count=1.
- in_q high for 2 cycles then low (glitch) -> no out_rise; out_level stays 0; out_count stays 0.
- 256 clean rise/fall cycles -> out_count=255 (saturated). in_clr pulsed on the same cycle as the next commit -> out_count=1.
- Reset asserted 2 cycles into ST_RISE_CHK -> FSM returns to ST_LOW. No pulse until in_q has been re-held for 6 edges after release.
- LATCH_PAIR_CHECK_EN defined, in_q=in_q_bar=1 for 8 cycles -> out_err=1 after 6 edges and stays 1. in_clr -> out_err=0. Undefined build -> out_err stays 0.
